target_fifo_reader: RTL and testbench
=====================================

Name: target_fifo_reader

Overview:
- Read-side consumer of the target-record FIFO. Drives the FIFO's level-sensitive read request and honours its read strobe. Pulls each 32-bit record and decodes it as either a target-start or a target-end record.
- Pairs each start record with the following end record and emits one target report per pair. The report carries start/end range cell, width, bearing, frequency flags and door flag.
- Sits between the FIFO read port and the downstream report/track logic. Runs entirely on the FIFO read clock.

Parameters:
- TMO_CYC, 64: max cycles to wait for each rdstb edge before aborting a read.
- GAP_CYC, 3: idle cycles after each read before flags are re-sampled; min 2 so rden has a low period.
- CNT_W, 8: width of the saturating error counters.

Ports:
- rdclk  in  1  block clock (FIFO read clock).
- reset  in  1  asynchronous, active-low reset.
- en  in  1  allow new reads; low finishes the current read, then idles.
- clr  in  1  synchronous: clears open-start state, error counters and err_tmo.
- rdstb  in  1  FIFO read strobe: high = FIFO reader idle/data ready, low = read in progress.
- rddata  in  32  FIFO record.
- rdstate  in  3  FIFO flags: [0] full, [1] almost full, [2] empty.
- rden  out  1  read request; FIFO acts on its rising edge.
- busy  out  1  high in any state other than IDLE.
- tgt_valid  out  1  one-cycle pulse when a report is valid.
- tgt_addr_s  out  10  start range cell.
- tgt_addr_e  out  10  end range cell.
- tgt_width  out  10  (addr_e - addr_s) mod 1024.
- tgt_bear  out  12  bearing from the start record.
- tgt_freq  out  2  {f2,f1} from the start record.
- tgt_door  out  1  OR of the door bits of start and end.
- err_orph_s  out  CNT_W  start records overwritten by a second start.
- err_orph_e  out  CNT_W  end records with no open start, or with a freq mismatch.
- err_fmt  out  CNT_W  records with an invalid type or non-zero bits [28:24].
- err_tmo  out  1  sticky: a read timed out.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, no open start, counters 0.
- Record format: [31:30] type (01 = start, 10 = end), [29] door, [28:24] must be 0, [23:22] freq, [21:10] bear, [9:0] addr.
- FSM states and transitions:
  - IDLE: go to REQ when en & rdstb & !rdstate[2]; rden = 0.
  - REQ: rden = 1, timer runs; rdstb low -> WAIT; timer reaches TMO_CYC -> ABORT.
  - WAIT: rden = 0, timer restarts; rdstb high -> CAP; timer reaches TMO_CYC -> ABORT.
  - CAP: register rddata -> DEC.
  - DEC: decode the record, update pairing and counters -> GAP.
  - GAP: count GAP_CYC cycles -> IDLE.
  - ABORT: set err_tmo, rden = 0 -> GAP.
- Latency: the rdstb rising edge is sampled in WAIT at edge N; the word is captured at N+1; tgt_valid is high in the cycle after edge N+2.
- Pairing rules:
  - Start with no open start: store it.
  - Start with a start already open: err_orph_s++, the new start replaces the old one.
  - End with an open start and equal freq: emit a report and clear the open start.
  - End with no open start, or freq mismatch: err_orph_e++; any open start is kept.
- Width: 10-bit modular subtraction, so a wrap across cell 1023 is valid.
- Format error: err_fmt++; pairing state is unchanged.
- Counters saturate at all-ones and do not wrap.
- clr while busy: the transaction completes; clr acts in the cycle it is asserted.
- en drop mid-read: the current read completes, including its report.
- Empty flag: sampled only in IDLE, so a stale empty lasts at most GAP_CYC cycles.
- Full/almost-full flags are not used by this block.

Decomposition:
- Shared package holds:
  - record field bit positions;
  - TYPE_START = 2'b01, TYPE_END = 2'b10;
  - one-hot FSM state encodings;
  - flag bit indices EMPTY = 2, AFULL = 1, FULL = 0.
- Sub-module tgt_pair_unit holds the open-start register, pairing logic, width arithmetic and the three counters.
- The top level holds the read-handshake FSM and the timers.

Test Plan:
- Basic pair: 0x40448C50 then 0x80448C58, rdstate = 0 -> one tgt_valid with addr_s = 0x050, addr_e = 0x058, width = 8, bear = 0x123, freq = 01.
- Wrap: 0x40448FFC then 0x80448C04 -> width = 8, addr_s = 0x3FC, addr_e = 0x004.
- Errors:
  - sequence start, start, end -> err_orph_s = 1 and one report using the second start;
  - lone end -> err_orph_e = 1;
  - 0xC0000000 -> err_fmt = 1, no report.
- Timeout: hold rdstb high after rden rises -> rden falls after 64 cycles, err_tmo = 1, block returns to IDLE.
- Empty/flow control:
  - rdstate = 3'b100 -> rden stays 0 for 1000 cycles;
  - rdstb low in IDLE -> no request issued;
  - rden low for ≥ 3 cycles between reads.
- Reset during WAIT -> rden = 0, busy = 0, counters 0 immediately (asynchronous); the next valid pair produces a correct report.

Source files
------------

// File: rtl/target_fifo_reader_pkg.sv
// Shared definitions for the target-record FIFO reader: record layout, record types,
// FIFO flag indices and the one-hot read-handshake state encoding.
package target_fifo_reader_pkg;

    localparam int REC_W    = 32;
    localparam int ADDR_W   = 10;
    localparam int BEAR_W   = 12;
    localparam int FREQ_W   = 2;

    localparam int TYPE_HI  = 31;
    localparam int TYPE_LO  = 30;
    localparam int DOOR_BIT = 29;
    localparam int RSV_HI   = 28;
    localparam int RSV_LO   = 24;
    localparam int FREQ_HI  = 23;
    localparam int FREQ_LO  = 22;
    localparam int BEAR_HI  = 21;
    localparam int BEAR_LO  = 10;
    localparam int ADDR_HI  = 9;
    localparam int ADDR_LO  = 0;

    localparam logic [1:0] TYPE_START = 2'b01;
    localparam logic [1:0] TYPE_END   = 2'b10;

    localparam int EMPTY = 2;
    localparam int AFULL = 1;
    localparam int FULL  = 0;

    typedef enum logic [6:0] {
        S_IDLE  = 7'b000_0001,
        S_REQ   = 7'b000_0010,
        S_WAIT  = 7'b000_0100,
        S_CAP   = 7'b000_1000,
        S_DEC   = 7'b001_0000,
        S_GAP   = 7'b010_0000,
        S_ABORT = 7'b100_0000
    } state_e;

    typedef struct packed {
        logic [1:0]        rtype;
        logic              door;
        logic [4:0]        rsv;
        logic [FREQ_W-1:0] freq;
        logic [BEAR_W-1:0] bear;
        logic [ADDR_W-1:0] addr;
    } rec_t;

    function automatic rec_t decode_rec(input logic [REC_W-1:0] w);
        rec_t r;
        r.rtype = w[TYPE_HI:TYPE_LO];
        r.door  = w[DOOR_BIT];
        r.rsv   = w[RSV_HI:RSV_LO];
        r.freq  = w[FREQ_HI:FREQ_LO];
        r.bear  = w[BEAR_HI:BEAR_LO];
        r.addr  = w[ADDR_HI:ADDR_LO];
        return r;
    endfunction

    function automatic logic rec_fmt_ok(input rec_t r);
        return ((r.rtype == TYPE_START) || (r.rtype == TYPE_END)) && (r.rsv == '0);
    endfunction

endpackage

// File: rtl/target_fifo_reader_pair_unit.sv
// Pairs start and end records into target reports; owns the open-start register,
// the range-width arithmetic and the saturating error counters.
module tgt_pair_unit
    import target_fifo_reader_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              dec_i,
    input  logic [REC_W-1:0]  rec_i,
    output logic              tgt_valid_o,
    output logic [ADDR_W-1:0] addr_s_o,
    output logic [ADDR_W-1:0] addr_e_o,
    output logic [ADDR_W-1:0] width_o,
    output logic [BEAR_W-1:0] bear_o,
    output logic [FREQ_W-1:0] freq_o,
    output logic              door_o,
    output logic [CNT_W-1:0]  err_orph_s_o,
    output logic [CNT_W-1:0]  err_orph_e_o,
    output logic [CNT_W-1:0]  err_fmt_o
);

    typedef struct packed {
        logic              door;
        logic [FREQ_W-1:0] freq;
        logic [BEAR_W-1:0] bear;
        logic [ADDR_W-1:0] addr;
    } open_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr_s;
        logic [ADDR_W-1:0] addr_e;
        logic [ADDR_W-1:0] width;
        logic [BEAR_W-1:0] bear;
        logic [FREQ_W-1:0] freq;
        logic              door;
    } rpt_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    rec_t             rec;
    logic             open_q, open_d;
    open_t            start_q, start_d;
    rpt_t             rpt_q, rpt_d;
    logic [CNT_W-1:0] orph_s_q, orph_s_d;
    logic [CNT_W-1:0] orph_e_q, orph_e_d;
    logic [CNT_W-1:0] fmt_q, fmt_d;

    // NOTE: every always_comb output gets its default first so no path can infer a latch.
    always_comb begin
        rec       = decode_rec(rec_i);
        open_d    = open_q;
        start_d   = start_q;
        rpt_d     = rpt_q;
        rpt_d.valid = 1'b0;
        orph_s_d  = orph_s_q;
        orph_e_d  = orph_e_q;
        fmt_d     = fmt_q;

        if (dec_i) begin
            if (!rec_fmt_ok(rec)) begin
                fmt_d = sat_inc(fmt_q);
            end else if (rec.rtype == TYPE_START) begin
                if (open_q) orph_s_d = sat_inc(orph_s_q);
                open_d  = 1'b1;
                start_d = '{door: rec.door, freq: rec.freq, bear: rec.bear, addr: rec.addr};
            end else if (open_q && (rec.freq == start_q.freq)) begin
                // Modular subtraction keeps targets straddling cell 1023 valid.
                rpt_d = '{valid:  1'b1,
                          addr_s: start_q.addr,
                          addr_e: rec.addr,
                          width:  rec.addr - start_q.addr,
                          bear:   start_q.bear,
                          freq:   start_q.freq,
                          door:   start_q.door | rec.door};
                open_d = 1'b0;
            end else begin
                orph_e_d = sat_inc(orph_e_q);
            end
        end

        if (clr_i) begin
            open_d   = 1'b0;
            orph_s_d = '0;
            orph_e_d = '0;
            fmt_d    = '0;
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q   <= 1'b0;
            start_q  <= '0;
            rpt_q    <= '0;
            orph_s_q <= '0;
            orph_e_q <= '0;
            fmt_q    <= '0;
        end else begin
            open_q   <= open_d;
            start_q  <= start_d;
            rpt_q    <= rpt_d;
            orph_s_q <= orph_s_d;
            orph_e_q <= orph_e_d;
            fmt_q    <= fmt_d;
        end
    end

    assign tgt_valid_o  = rpt_q.valid;
    assign addr_s_o     = rpt_q.addr_s;
    assign addr_e_o     = rpt_q.addr_e;
    assign width_o      = rpt_q.width;
    assign bear_o       = rpt_q.bear;
    assign freq_o       = rpt_q.freq;
    assign door_o       = rpt_q.door;
    assign err_orph_s_o = orph_s_q;
    assign err_orph_e_o = orph_e_q;
    assign err_fmt_o    = fmt_q;

endmodule

// File: rtl/target_fifo_reader.sv
// Read-side consumer of the target-record FIFO: drives the rden/rdstb handshake with
// per-phase timeouts and hands each captured record to the pairing unit.
module target_fifo_reader
    import target_fifo_reader_pkg::*;
#(
    parameter int TMO_CYC = 64,
    parameter int GAP_CYC = 3,
    parameter int CNT_W   = 8
) (
    input  logic              rdclk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic              rdstb,
    input  logic [REC_W-1:0]  rddata,
    input  logic [2:0]        rdstate,
    output logic              rden,
    output logic              busy,
    output logic              tgt_valid,
    output logic [ADDR_W-1:0] tgt_addr_s,
    output logic [ADDR_W-1:0] tgt_addr_e,
    output logic [ADDR_W-1:0] tgt_width,
    output logic [BEAR_W-1:0] tgt_bear,
    output logic [FREQ_W-1:0] tgt_freq,
    output logic              tgt_door,
    output logic [CNT_W-1:0]  err_orph_s,
    output logic [CNT_W-1:0]  err_orph_e,
    output logic [CNT_W-1:0]  err_fmt,
    output logic              err_tmo
);

    localparam int TMR_W = $clog2((TMO_CYC > GAP_CYC) ? TMO_CYC : GAP_CYC) + 1;
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TMO_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYC - 1);

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [REC_W-1:0]   rec_q, rec_d;
    logic               err_tmo_q, err_tmo_d;
    logic               dec;

    // Full and almost-full are deliberately ignored; only the empty flag gates reads.
    logic unused_flags;
    assign unused_flags = rdstate[FULL] ^ rdstate[AFULL];

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 1'b1;
        rec_d     = rec_q;
        err_tmo_d = err_tmo_q;
        dec       = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (en && rdstb && !rdstate[EMPTY]) state_d = S_REQ;
            end
            S_REQ: begin
                if (!rdstb)                  state_d = S_WAIT;
                else if (timer_q == TMO_LAST) state_d = S_ABORT;
            end
            S_WAIT: begin
                if (rdstb)                   state_d = S_CAP;
                else if (timer_q == TMO_LAST) state_d = S_ABORT;
            end
            S_CAP: begin
                rec_d   = rddata;
                state_d = S_DEC;
            end
            S_DEC: begin
                dec     = 1'b1;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (timer_q == GAP_LAST) state_d = S_IDLE;
            end
            S_ABORT: begin
                err_tmo_d = 1'b1;
                state_d   = S_GAP;
            end
            default: state_d = S_IDLE;
        endcase

        // Each timed phase starts counting from zero on entry.
        if (state_d != state_q) timer_d = '0;
        if (clr) err_tmo_d = 1'b0;
    end

    always_ff @(posedge rdclk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            rec_q     <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            rec_q     <= rec_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    assign rden    = (state_q == S_REQ);
    assign busy    = (state_q != S_IDLE);
    assign err_tmo = err_tmo_q;

    tgt_pair_unit #(.CNT_W(CNT_W)) u_pair (
        .clk          (rdclk),
        .rst_n        (reset),
        .clr_i        (clr),
        .dec_i        (dec),
        .rec_i        (rec_q),
        .tgt_valid_o  (tgt_valid),
        .addr_s_o     (tgt_addr_s),
        .addr_e_o     (tgt_addr_e),
        .width_o      (tgt_width),
        .bear_o       (tgt_bear),
        .freq_o       (tgt_freq),
        .door_o       (tgt_door),
        .err_orph_s_o (err_orph_s),
        .err_orph_e_o (err_orph_e),
        .err_fmt_o    (err_fmt)
    );

endmodule

// File: tb/tb_target_fifo_reader.sv
// Bench for target_fifo_reader: a behavioural FIFO answers rden, expected reports are
// queued from a vector table and compared as tgt_valid pulses appear.
module tb_target_fifo_reader;

    localparam int CNT_W   = 8;
    localparam int TMO_CYC = 64;
    localparam int GAP_CYC = 3;

    logic        rdclk   = 1'b0;
    logic        reset   = 1'b0;
    logic        en      = 1'b0;
    logic        clr     = 1'b0;
    logic        rdstb   = 1'b1;
    logic [31:0] rddata  = '0;
    logic [2:0]  rdstate = 3'b100;

    logic             rden, busy, tgt_valid, tgt_door, err_tmo;
    logic [9:0]       tgt_addr_s, tgt_addr_e, tgt_width;
    logic [11:0]      tgt_bear;
    logic [1:0]       tgt_freq;
    logic [CNT_W-1:0] err_orph_s, err_orph_e, err_fmt;

    always #5 rdclk = ~rdclk;

    target_fifo_reader #(.TMO_CYC(TMO_CYC), .GAP_CYC(GAP_CYC), .CNT_W(CNT_W)) dut (
        .rdclk      (rdclk),
        .reset      (reset),
        .en         (en),
        .clr        (clr),
        .rdstb      (rdstb),
        .rddata     (rddata),
        .rdstate    (rdstate),
        .rden       (rden),
        .busy       (busy),
        .tgt_valid  (tgt_valid),
        .tgt_addr_s (tgt_addr_s),
        .tgt_addr_e (tgt_addr_e),
        .tgt_width  (tgt_width),
        .tgt_bear   (tgt_bear),
        .tgt_freq   (tgt_freq),
        .tgt_door   (tgt_door),
        .err_orph_s (err_orph_s),
        .err_orph_e (err_orph_e),
        .err_fmt    (err_fmt),
        .err_tmo    (err_tmo)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [9:0]  a_s;
        logic [9:0]  a_e;
        logic [9:0]  wd;
        logic [11:0] br;
        logic [1:0]  fq;
        logic        dr;
    } rep_t;

    typedef struct packed {
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic        rep;
        rep_t        r;
        int          eos;
        int          eoe;
        int          efmt;
    } vec_t;

    function automatic vec_t mk(input int n, input logic [31:0] w0, w1, w2, input logic rep,
                                input logic [9:0] a_s, a_e, wd, input logic [11:0] br,
                                input logic [1:0] fq, input logic dr, input int eos, eoe, efmt);
        vec_t v;
        v.n = n; v.w0 = w0; v.w1 = w1; v.w2 = w2; v.rep = rep;
        v.r = '{a_s: a_s, a_e: a_e, wd: wd, br: br, fq: fq, dr: dr};
        v.eos = eos; v.eoe = eoe; v.efmt = efmt;
        return v;
    endfunction

    // Behavioural FIFO read port: on a rising rden it drops rdstb, then presents the
    // next word and raises rdstb again.
    logic [31:0] fifo_q[$];
    rep_t        exp_q[$];
    logic        respond   = 1'b1;
    logic        force_low = 1'b0;
    logic        stb_low   = 1'b0;
    logic        rden_prev = 1'b0;
    int          phase     = 0;
    int          pcnt      = 0;

    initial begin
        forever begin
            @(negedge rdclk);
            case (phase)
                0: if (rden && !rden_prev && respond) begin phase = 1; pcnt = 0; end
                1: begin
                    pcnt++;
                    if (pcnt == 2) begin stb_low = 1'b1; phase = 2; pcnt = 0; end
                end
                default: begin
                    pcnt++;
                    if (pcnt == 3) begin
                        rddata  = (fifo_q.size() > 0) ? fifo_q.pop_front() : 32'h0;
                        stb_low = 1'b0;
                        phase   = 0;
                    end
                end
            endcase
            rden_prev = rden;
            rdstb     = !stb_low && !force_low;
            rdstate   = {fifo_q.size() == 0, 2'($urandom_range(0, 3))};
        end
    end

    // Monitor: request-gap check and report scoreboard.
    int   rden_rises = 0;
    int   low_run    = 100;
    logic mon_prev   = 1'b0;

    initial begin
        rep_t e;
        forever begin
            @(negedge rdclk);
            if (rden && !mon_prev) begin
                rden_rises++;
                check("rden_low_gap_ok", 32'(low_run >= GAP_CYC), 1);
            end
            low_run  = rden ? 0 : low_run + 1;
            mon_prev = rden;
            if (tgt_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_report", 32'(tgt_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("addr_s", 32'(tgt_addr_s), 32'(e.a_s));
                    check("addr_e", 32'(tgt_addr_e), 32'(e.a_e));
                    check("width",  32'(tgt_width),  32'(e.wd));
                    check("bear",   32'(tgt_bear),   32'(e.br));
                    check("freq",   32'(tgt_freq),   32'(e.fq));
                    check("door",   32'(tgt_door),   32'(e.dr));
                end
            end
        end
    end

    task automatic pulse_clr();
        @(negedge rdclk) clr = 1'b1;
        @(negedge rdclk) clr = 1'b0;
    endtask

    task automatic drain(input string nm, input int budget);
        int c = 0;
        do begin
            @(negedge rdclk);
            c++;
        end while (!(fifo_q.size() == 0 && phase == 0 && !busy) && c < budget);
        repeat (2) @(negedge rdclk);
        check({nm, "_drained"}, 32'(c < budget), 1);
    endtask

    task automatic check_cnt(input string nm, input int os, input int oe, input int fm);
        check({nm, "_err_orph_s"}, 32'(err_orph_s), 32'(os));
        check({nm, "_err_orph_e"}, 32'(err_orph_e), 32'(oe));
        check({nm, "_err_fmt"},    32'(err_fmt),    32'(fm));
    endtask

    vec_t vecs[9];

    initial begin
        int c;
        int r0;

        vecs[0] = mk(2, 32'h40448C50, 32'h80448C58, 0, 1, 10'h050, 10'h058, 10'h008, 12'h123, 2'b01, 1'b0, 0, 0, 0);
        vecs[1] = mk(2, 32'h40448FFC, 32'h80448C04, 0, 1, 10'h3FC, 10'h004, 10'h008, 12'h123, 2'b01, 1'b0, 0, 0, 0);
        vecs[2] = mk(3, 32'h40448C50, 32'h40448C60, 32'h80448C68, 1, 10'h060, 10'h068, 10'h008, 12'h123, 2'b01, 1'b0, 1, 0, 0);
        vecs[3] = mk(1, 32'h80448C58, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[4] = mk(1, 32'hC0000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[5] = mk(2, 32'h60800010, 32'h80800020, 0, 1, 10'h010, 10'h020, 10'h010, 12'h000, 2'b10, 1'b1, 0, 0, 0);
        vecs[6] = mk(3, 32'h40448C50, 32'h80848C58, 32'h80448C70, 1, 10'h050, 10'h070, 10'h020, 12'h123, 2'b01, 1'b0, 0, 1, 0);
        vecs[7] = mk(2, 32'h41448C50, 32'h80448C58, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        vecs[8] = mk(2, 32'h403FFC00, 32'hA00003FF, 0, 1, 10'h000, 10'h3FF, 10'h3FF, 12'hFFF, 2'b00, 1'b1, 0, 0, 0);

        // Reset state.
        repeat (3) @(negedge rdclk);
        check("rst_rden", 32'(rden), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_tgt_valid", 32'(tgt_valid), 0);
        check("rst_err_tmo", 32'(err_tmo), 0);
        check("rst_width", 32'(tgt_width), 0);
        check_cnt("rst", 0, 0, 0);
        reset = 1'b1;
        en    = 1'b1;

        // rdstb low in IDLE: data waiting but no request may issue.
        force_low = 1'b1;
        repeat (2) @(negedge rdclk);
        fifo_q.push_back(32'h80448C58);
        repeat (50) @(negedge rdclk);
        check("no_req_stb_low", 32'(rden_rises), 0);
        force_low = 1'b0;
        drain("stb_release", 400);
        check_cnt("stb_release", 0, 1, 0);

        // Empty FIFO: no request for 1000 cycles.
        r0 = rden_rises;
        repeat (1000) @(negedge rdclk);
        check("no_req_empty", 32'(rden_rises - r0), 0);

        foreach (vecs[i]) begin
            pulse_clr();
            if (vecs[i].rep) exp_q.push_back(vecs[i].r);
            fifo_q.push_back(vecs[i].w0);
            if (vecs[i].n > 1) fifo_q.push_back(vecs[i].w1);
            if (vecs[i].n > 2) fifo_q.push_back(vecs[i].w2);
            drain($sformatf("vec%0d", i), 600);
            check_cnt($sformatf("vec%0d", i), vecs[i].eos, vecs[i].eoe, vecs[i].efmt);
            check($sformatf("vec%0d_pending_reports", i), 32'(exp_q.size()), 0);
        end

        // Saturation of a counter.
        pulse_clr();
        repeat (260) fifo_q.push_back(32'hC0000000);
        drain("saturate", 8000);
        check("sat_err_fmt", 32'(err_fmt), 32'hFF);

        // Timeout: FIFO never drops rdstb; en dropped mid-read.
        pulse_clr();
        respond = 1'b0;
        fifo_q.push_back(32'hC0000000);
        c = 0;
        while (!rden && c < 100) begin @(negedge rdclk); c++; end
        check("tmo_req_seen", 32'(rden), 1);
        en = 1'b0;
        c  = 0;
        while (rden && c < 200) begin c++; @(negedge rdclk); end
        check("tmo_rden_cycles", 32'(c), 32'(TMO_CYC));
        repeat (2) @(negedge rdclk);
        check("tmo_err_tmo", 32'(err_tmo), 1);
        c = 0;
        while (busy && c < 50) begin @(negedge rdclk); c++; end
        check("tmo_idle_busy", 32'(busy), 0);
        repeat (5) @(negedge rdclk);
        check("tmo_idle_rden", 32'(rden), 0);
        respond = 1'b1;
        en      = 1'b1;
        fifo_q.push_back(32'h80448C58);
        drain("after_tmo", 600);
        check_cnt("after_tmo", 0, 1, 1);
        check("after_tmo_err_tmo", 32'(err_tmo), 1);

        // Asynchronous reset while the block waits for rdstb to rise.
        fifo_q.push_back(32'h40448C50);
        c = 0;
        do begin @(posedge rdclk); #1; c++; end while (!(rdstb == 1'b0 && busy) && c < 100);
        check("wait_busy", 32'(busy), 1);
        #2 reset = 1'b0;
        #1;
        check("arst_rden", 32'(rden), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_err_tmo", 32'(err_tmo), 0);
        check_cnt("arst", 0, 0, 0);
        repeat (2) @(negedge rdclk);
        reset = 1'b1;
        c = 0;
        while (phase != 0 && c < 50) begin @(negedge rdclk); c++; end
        exp_q.push_back(vecs[0].r);
        fifo_q.push_back(vecs[0].w0);
        fifo_q.push_back(vecs[0].w1);
        drain("post_rst", 600);
        check_cnt("post_rst", 0, 0, 0);
        check("post_rst_pending_reports", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
